// File: rtl/reg_native2apb_mst.sv
// Bridges one reg_native_if request at a time onto an APB master port and returns the acknowledge.
// Optional access-phase watchdog: define REG_NATIVE2APB_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module reg_native2apb_mst #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  fsm_clk,
    input  logic                  fsm_rstn,
    input  logic                  soft_rst,
    input  logic                  req_vld,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  ack_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  err,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  PREADY,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PSLVERR,
    output logic [1:0]            fsm_state
);

    // Handshake: req_vld is a one-cycle strobe accepted only in IDLE; every accepted
    // request yields exactly one one-cycle ack_vld carrying rd_data/err, unless a reset
    // intervenes. Requests arriving outside IDLE are dropped.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        ACK    = 2'd3
    } state_t;

    state_t state;
    logic   to_hit;

    assign fsm_state = state;

`ifdef REG_NATIVE2APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt;

    // Fires on the stalled ACCESS edge that would bring the count to TIMEOUT_CYCLES.
    assign to_hit = (state == ACCESS) && !PREADY && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge fsm_clk or negedge fsm_rstn) begin
        if (!fsm_rstn) begin
            to_cnt <= '0;
        end else if (soft_rst) begin
            to_cnt <= '0;
        end else if (state == IDLE && req_vld && (wr_en || rd_en)) begin
            to_cnt <= '0;
        end else if (state == ACCESS && !PREADY) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
    assign to_hit         = 1'b0;
`endif

    always_ff @(posedge fsm_clk or negedge fsm_rstn) begin
        if (!fsm_rstn) begin
            state   <= IDLE;
            ack_vld <= 1'b0;
            rd_data <= '0;
            err     <= 1'b0;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
        end else if (soft_rst) begin
            state   <= IDLE;
            ack_vld <= 1'b0;
            rd_data <= '0;
            err     <= 1'b0;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_vld) begin
                        if (wr_en || rd_en) begin
                            // Write takes precedence when both enables are set.
                            state  <= SETUP;
                            PSEL   <= 1'b1;
                            PWRITE <= wr_en;
                            PADDR  <= addr;
                            PWDATA <= wr_data;
                        end else begin
                            state   <= ACK;
                            ack_vld <= 1'b1;
                            rd_data <= '0;
                            err     <= 1'b0;
                        end
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    PENABLE <= 1'b1;
                end
                ACCESS: begin
                    if (PREADY) begin
                        state   <= ACK;
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        ack_vld <= 1'b1;
                        rd_data <= PWRITE ? '0 : PRDATA;
                        err     <= PSLVERR;
                    end else if (to_hit) begin
                        state   <= ACK;
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        ack_vld <= 1'b1;
                        rd_data <= '1;
                        err     <= 1'b1;
                    end
                end
                ACK: begin
                    state   <= IDLE;
                    ack_vld <= 1'b0;
                    rd_data <= '0;
                    err     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_native2apb_mst.sv
// Bench for reg_native2apb_mst: behavioural APB slave, transaction-level reference model, directed and random scenarios.
module tb_reg_native2apb_mst;
    localparam int AW = 64;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          fsm_clk = 1'b0;
    logic          fsm_rstn, soft_rst, req_vld, wr_en, rd_en;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic          ack_vld, err, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [DW-1:0] rd_data, PWDATA, PRDATA;
    logic [AW-1:0] PADDR;
    logic [1:0]    fsm_state;

    int checks = 0;
    int failures = 0;
    int ack_count = 0;

    int            slv_wait = 0;
    logic          slv_err = 1'b0;
    int            slv_cnt = 0;
    bit [DW-1:0]   slv_mem[bit [7:0]];
    bit [DW-1:0]   ref_mem[bit [7:0]];
    logic [DW-1:0] exp_q[$];

    reg_native2apb_mst #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .fsm_clk(fsm_clk), .fsm_rstn(fsm_rstn), .soft_rst(soft_rst),
        .req_vld(req_vld), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wr_data(wr_data),
        .ack_vld(ack_vld), .rd_data(rd_data), .err(err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR), .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 fsm_clk = ~fsm_clk;

    always @(negedge fsm_clk) if (ack_vld === 1'b1) ack_count++;

    function automatic bit [DW-1:0] ref_rd(input bit [7:0] k);
        return ref_mem.exists(k) ? ref_mem[k] : '0;
    endfunction

    // APB slave: inserts slv_wait wait states, then completes with slv_err.
    initial begin
        PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
        forever begin
            @(negedge fsm_clk);
            if (PSEL === 1'b1 && PENABLE === 1'b1) begin
                if (slv_cnt >= slv_wait) begin
                    PREADY  = 1'b1;
                    PSLVERR = slv_err;
                    if (PWRITE) begin
                        PRDATA = $urandom;
                        if (!slv_err) slv_mem[PADDR[7:0]] = PWDATA;
                    end else begin
                        PRDATA = slv_mem.exists(PADDR[7:0]) ? slv_mem[PADDR[7:0]] : '0;
                    end
                end else begin
                    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom;
                end
                slv_cnt++;
            end else begin
                PREADY = 1'b0; PSLVERR = 1'b0; slv_cnt = 0;
            end
        end
    end

    // driver: issues one request at a negedge and observes it until ack (bounded)
    task automatic run_txn(input logic w, input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int waits, input logic e_inj, input int dup_at,
                           output int lat, output logic [DW-1:0] rdat, output logic rerr,
                           output logic post_ack, output logic [DW-1:0] post_rdat, output logic post_err,
                           output int psel_n, output int pen_n,
                           output logic [AW-1:0] s_addr, output logic [DW-1:0] s_wdata, output logic s_write);
        slv_wait = waits; slv_err = e_inj;
        lat = -1; rdat = 'x; rerr = 1'bx; psel_n = 0; pen_n = 0;
        s_addr = 'x; s_wdata = 'x; s_write = 1'bx;
        req_vld = 1'b1; wr_en = w; rd_en = r; addr = a; wr_data = d;
        for (int c = 1; c <= 50; c++) begin
            @(negedge fsm_clk);
            req_vld = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
            if (c == dup_at) begin
                req_vld = 1'b1; wr_en = 1'b1; addr = a ^ 64'h40; wr_data = ~d;
            end
            if (PSEL === 1'b1) psel_n++;
            if (PENABLE === 1'b1) pen_n++;
            if (PSEL === 1'b1 && PENABLE === 1'b0) begin
                s_addr = PADDR; s_wdata = PWDATA; s_write = PWRITE;
            end
            if (ack_vld === 1'b1) begin
                lat = c; rdat = rd_data; rerr = err;
                break;
            end
        end
        @(negedge fsm_clk);
        req_vld = 1'b0;
        post_ack = ack_vld; post_rdat = rd_data; post_err = err;
    endtask

    task automatic test_reset();
        fsm_rstn = 1'b0; soft_rst = 1'b0; req_vld = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        addr = '0; wr_data = '0;
        repeat (3) @(negedge fsm_clk);
        checks++; if ({ack_vld, err} !== 2'b00) begin failures++; $display("FAIL reset_ack_err got=%b exp=00", {ack_vld, err}); end
        checks++; if (rd_data !== '0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
        checks++; if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin failures++; $display("FAIL reset_apb_ctl got=%b exp=000", {PSEL, PENABLE, PWRITE}); end
        checks++; if (PADDR !== '0) begin failures++; $display("FAIL reset_paddr got=%h exp=0", PADDR); end
        checks++; if (PWDATA !== '0) begin failures++; $display("FAIL reset_pwdata got=%h exp=0", PWDATA); end
        fsm_rstn = 1'b1;
        repeat (2) @(negedge fsm_clk);
        checks++; if ({ack_vld, PSEL} !== 2'b00) begin failures++; $display("FAIL reset_idle got=%b exp=00", {ack_vld, PSEL}); end
    endtask

    task automatic test_write_zero_wait();
        int lat, pn, en; logic [DW-1:0] rd, prd, sw; logic e, pa, pe, swr; logic [AW-1:0] sa;
        run_txn(1'b1, 1'b0, 64'h10, 32'hA5A5A5A5, 0, 1'b0, 0, lat, rd, e, pa, prd, pe, pn, en, sa, sw, swr);
        ref_mem[8'h10] = 32'hA5A5A5A5;
        checks++; if (lat !== 3) begin failures++; $display("FAIL wr0_latency got=%0d exp=3", lat); end
        checks++; if ({rd, e} !== {32'h0, 1'b0}) begin failures++; $display("FAIL wr0_ack got=%h/%b exp=0/0", rd, e); end
        checks++; if ({pn, en} !== {32'd2, 32'd1}) begin failures++; $display("FAIL wr0_phases got=psel%0d/pen%0d exp=2/1", pn, en); end
        checks++; if ({sa, sw, swr} !== {64'h10, 32'hA5A5A5A5, 1'b1}) begin failures++; $display("FAIL wr0_setup got=%h/%h/%b exp=10/a5a5a5a5/1", sa, sw, swr); end
        checks++; if ({PSEL, PENABLE, PADDR, PWDATA} !== {2'b00, 64'h10, 32'hA5A5A5A5}) begin failures++; $display("FAIL wr0_hold got=%b%b/%h/%h exp=00/10/a5a5a5a5", PSEL, PENABLE, PADDR, PWDATA); end
        checks++; if (pa !== 1'b0) begin failures++; $display("FAIL wr0_ack_len got=%b exp=0", pa); end
    endtask

    task automatic test_read_wait();
        int lat, pn, en; logic [DW-1:0] rd, prd, sw; logic e, pa, pe, swr; logic [AW-1:0] sa;
        slv_mem[8'h20] = 32'h12345678; ref_mem[8'h20] = 32'h12345678;
        run_txn(1'b0, 1'b1, 64'h20, 32'h0, 3, 1'b0, 0, lat, rd, e, pa, prd, pe, pn, en, sa, sw, swr);
        checks++; if (lat !== 6) begin failures++; $display("FAIL rd3_latency got=%0d exp=6", lat); end
        checks++; if ({rd, e} !== {32'h12345678, 1'b0}) begin failures++; $display("FAIL rd3_data got=%h/%b exp=12345678/0", rd, e); end
        checks++; if ({pn, en} !== {32'd5, 32'd4}) begin failures++; $display("FAIL rd3_held got=psel%0d/pen%0d exp=5/4", pn, en); end
        checks++; if ({pa, prd, pe} !== {1'b0, 32'h0, 1'b0}) begin failures++; $display("FAIL rd3_clear got=%b/%h/%b exp=0/0/0", pa, prd, pe); end
    endtask

    task automatic test_pslverr();
        int lat, pn, en; logic [DW-1:0] rd, prd, sw; logic e, pa, pe, swr; logic [AW-1:0] sa;
        run_txn(1'b0, 1'b1, 64'h20, 32'h0, 1, 1'b1, 0, lat, rd, e, pa, prd, pe, pn, en, sa, sw, swr);
        checks++; if ({lat, rd, e} !== {32'd4, ref_rd(8'h20), 1'b1}) begin failures++; $display("FAIL slverr_ack got=%0d/%h/%b exp=4/%h/1", lat, rd, e, ref_rd(8'h20)); end
        checks++; if ({pa, pe, prd} !== {2'b00, 32'h0}) begin failures++; $display("FAIL slverr_next got=%b/%b/%h exp=0/0/0", pa, pe, prd); end
    endtask

    task automatic test_illegal();
        int lat, pn, en; logic [DW-1:0] rd, prd, sw; logic e, pa, pe, swr; logic [AW-1:0] sa;
        run_txn(1'b0, 1'b0, 64'h44, 32'hDEADBEEF, 0, 1'b0, 0, lat, rd, e, pa, prd, pe, pn, en, sa, sw, swr);
        checks++; if ({lat, rd, e} !== {32'd1, 32'h0, 1'b0}) begin failures++; $display("FAIL illegal_ack got=%0d/%h/%b exp=1/0/0", lat, rd, e); end
        checks++; if ({pn, en, pa} !== {32'd0, 32'd0, 1'b0}) begin failures++; $display("FAIL illegal_no_apb got=psel%0d/pen%0d/ack%b exp=0/0/0", pn, en, pa); end
    endtask

    task automatic test_overlap();
        int lat, pn, en, a0, extra_psel; logic [DW-1:0] rd, prd, sw; logic e, pa, pe, swr; logic [AW-1:0] sa;
        slv_mem[8'h24] = 32'hCAFE0024; ref_mem[8'h24] = 32'hCAFE0024;
        slv_mem[8'h64] = 32'hBEEF0064; ref_mem[8'h64] = 32'hBEEF0064;
        a0 = ack_count; extra_psel = 0;
        run_txn(1'b0, 1'b1, 64'h24, 32'h13572468, 3, 1'b0, 3, lat, rd, e, pa, prd, pe, pn, en, sa, sw, swr);
        for (int i = 0; i < 8; i++) begin
            @(negedge fsm_clk);
            if (PSEL === 1'b1) extra_psel++;
        end
        checks++; if ({lat, rd} !== {32'd6, 32'hCAFE0024}) begin failures++; $display("FAIL overlap_first got=%0d/%h exp=6/cafe0024", lat, rd); end
        checks++; if (ack_count - a0 !== 1) begin failures++; $display("FAIL overlap_ack_count got=%0d exp=1", ack_count - a0); end
        checks++; if (extra_psel !== 0) begin failures++; $display("FAIL overlap_no_second_apb got=%0d exp=0", extra_psel); end
        run_txn(1'b0, 1'b1, 64'h64, 32'h0, 0, 1'b0, 0, lat, rd, e, pa, prd, pe, pn, en, sa, sw, swr);
        checks++; if (rd !== ref_rd(8'h64)) begin failures++; $display("FAIL overlap_not_written got=%h exp=%h", rd, ref_rd(8'h64)); end
    endtask

    task automatic test_both_enables();
        int lat, pn, en; logic [DW-1:0] rd, prd, sw; logic e, pa, pe, swr; logic [AW-1:0] sa;
        run_txn(1'b1, 1'b1, 64'h8, 32'h0F0F1234, 2, 1'b0, 0, lat, rd, e, pa, prd, pe, pn, en, sa, sw, swr);
        ref_mem[8'h8] = 32'h0F0F1234;
        checks++; if ({lat, rd, swr} !== {32'd5, 32'h0, 1'b1}) begin failures++; $display("FAIL both_is_write got=%0d/%h/%b exp=5/0/1", lat, rd, swr); end
        run_txn(1'b0, 1'b1, 64'h8, 32'h0, 0, 1'b0, 0, lat, rd, e, pa, prd, pe, pn, en, sa, sw, swr);
        checks++; if (rd !== ref_rd(8'h8)) begin failures++; $display("FAIL both_readback got=%h exp=%h", rd, ref_rd(8'h8)); end
    endtask

    task automatic test_random();
        int lat, pn, en, kind, waits, exp_lat, exp_pn; logic [DW-1:0] rd, prd, sw, d, exp_rd;
        logic e, pa, pe, swr, w, r, einj; logic [AW-1:0] sa, a; bit [7:0] k;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 3); waits = $urandom_range(0, 3);
            einj = ($urandom_range(0, 7) == 0);
            w = (kind == 1 || kind == 3); r = (kind == 2 || kind == 3);
            k = 8'($urandom_range(0, 15) * 4);
            a = {$urandom, $urandom}; a[7:0] = k; d = $urandom;
            if (!w && !r) begin
                exp_q.push_back('0); exp_lat = 1; exp_pn = 0; einj = 1'b0;
            end else begin
                exp_q.push_back(w ? '0 : ref_rd(k)); exp_lat = 3 + waits; exp_pn = waits + 2;
            end
            run_txn(w, r, a, d, waits, einj, 0, lat, rd, e, pa, prd, pe, pn, en, sa, sw, swr);
            if (w && !einj) ref_mem[k] = d;
            exp_rd = exp_q.pop_front();
            checks++; if ({lat, rd, e} !== {exp_lat, exp_rd, einj}) begin failures++; $display("FAIL rand%0d_ack got=%0d/%h/%b exp=%0d/%h/%b", n, lat, rd, e, exp_lat, exp_rd, einj); end
            checks++; if ({pn, pa, prd, pe} !== {exp_pn, 1'b0, 32'h0, 1'b0}) begin failures++; $display("FAIL rand%0d_phase got=%0d/%b/%h/%b exp=%0d/0/0/0", n, pn, pa, prd, pe, exp_pn); end
            if (exp_pn != 0) begin
                checks++; if ({sa, swr} !== {a, w}) begin failures++; $display("FAIL rand%0d_setup got=%h/%b exp=%h/%b", n, sa, swr, a, w); end
            end
        end
    endtask

    task automatic test_abort();
        int a0, lat, pn, en; logic [DW-1:0] rd, prd, sw; logic e, pa, pe, swr; logic [AW-1:0] sa;
        slv_wait = 20; slv_err = 1'b0;
        req_vld = 1'b1; wr_en = 1'b0; rd_en = 1'b1; addr = 64'h30;
        @(negedge fsm_clk); req_vld = 1'b0; rd_en = 1'b0;
        @(negedge fsm_clk);
        checks++; if ({PSEL, PENABLE} !== 2'b11) begin failures++; $display("FAIL abort_in_access got=%b exp=11", {PSEL, PENABLE}); end
        a0 = ack_count;
        #2 fsm_rstn = 1'b0;
        #1;
        checks++; if ({PSEL, PENABLE} !== 2'b00) begin failures++; $display("FAIL hard_rst_async got=%b exp=00", {PSEL, PENABLE}); end
        @(negedge fsm_clk); fsm_rstn = 1'b1;
        repeat (10) @(negedge fsm_clk);
        checks++; if (ack_count !== a0) begin failures++; $display("FAIL hard_rst_no_ack got=%0d exp=%0d", ack_count, a0); end

        req_vld = 1'b1; rd_en = 1'b1; addr = 64'h34;
        @(negedge fsm_clk); req_vld = 1'b0; rd_en = 1'b0;
        @(negedge fsm_clk);
        a0 = ack_count;
        soft_rst = 1'b1;
        #1;
        checks++; if ({PSEL, PENABLE} !== 2'b11) begin failures++; $display("FAIL soft_rst_sync got=%b exp=11", {PSEL, PENABLE}); end
        @(negedge fsm_clk);
        checks++; if ({PSEL, PENABLE, ack_vld} !== 3'b000) begin failures++; $display("FAIL soft_rst_drop got=%b exp=000", {PSEL, PENABLE, ack_vld}); end
        soft_rst = 1'b0;
        repeat (10) @(negedge fsm_clk);
        checks++; if (ack_count !== a0) begin failures++; $display("FAIL soft_rst_no_ack got=%0d exp=%0d", ack_count, a0); end

        run_txn(1'b1, 1'b0, 64'h3C, 32'h600DF00D, 1, 1'b0, 0, lat, rd, e, pa, prd, pe, pn, en, sa, sw, swr);
        ref_mem[8'h3C] = 32'h600DF00D;
        checks++; if ({lat, rd, e, pa} !== {32'd4, 32'h0, 2'b00}) begin failures++; $display("FAIL post_rst_write got=%0d/%h/%b/%b exp=4/0/0/0", lat, rd, e, pa); end
    endtask

    task automatic test_timeout();
        int lat; logic [DW-1:0] rd; logic e;
        slv_wait = 100000; slv_err = 1'b0; lat = -1; rd = '0; e = 1'b0;
        req_vld = 1'b1; wr_en = 1'b0; rd_en = 1'b1; addr = 64'h20;
        for (int c = 1; c <= 100; c++) begin
            @(negedge fsm_clk);
            req_vld = 1'b0; rd_en = 1'b0;
            if (ack_vld === 1'b1) begin lat = c; rd = rd_data; e = err; break; end
        end
`ifdef REG_NATIVE2APB_TIMEOUT_EN
        checks++; if ({lat, rd, e} !== {32'd6, 32'hFFFFFFFF, 1'b1}) begin failures++; $display("FAIL timeout_ack got=%0d/%h/%b exp=6/ffffffff/1", lat, rd, e); end
        @(negedge fsm_clk);
        checks++; if ({ack_vld, rd_data, err, PSEL} !== {1'b0, 32'h0, 2'b00}) begin failures++; $display("FAIL timeout_clear got=%b/%h/%b/%b exp=0/0/0/0", ack_vld, rd_data, err, PSEL); end
`else
        checks++; if (lat !== -1) begin failures++; $display("FAIL no_timeout_ack got=%0d exp=none", lat); end
        checks++; if ({PSEL, PENABLE} !== 2'b11) begin failures++; $display("FAIL no_timeout_wait got=%b exp=11", {PSEL, PENABLE}); end
        soft_rst = 1'b1;
        @(negedge fsm_clk); soft_rst = 1'b0;
        @(negedge fsm_clk);
`endif
        slv_wait = 0;
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_pslverr();
        test_illegal();
        test_overlap();
        test_both_enables();
        test_random();
        test_abort();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reg_native2apb_mst.md
Name: reg_native2apb_mst

Overview:
- Bridge that terminates a reg_native_if request from an upstream regmst or regslv forwarding path.
- Replays each request as an APB master transaction toward an external APB slave, such as third-party IP hung off the register tree.
- Returns completion and read data to the upstream as a reg_native_if acknowledge.
- Single outstanding transaction; one clock domain.

Parameters:
- ADDR_WIDTH, 64, width of addr and PADDR.
- DATA_WIDTH, 32, width of wr_data, rd_data, PWDATA and PRDATA.
- TIMEOUT_CYCLES, 255, maximum APB access-phase length in cycles before forced termination (used only with the optional feature).

Ports:
- fsm_clk  input  1  clock for the bridge and the APB side.
- fsm_rstn  input  1  asynchronous active-low reset.
- soft_rst  input  1  synchronous global soft reset from upstream; same effect as reset, applied at the clock edge.
- req_vld  input  1  one-cycle request strobe.
- wr_en  input  1  write request, qualified by req_vld.
- rd_en  input  1  read request, qualified by req_vld.
- addr  input  ADDR_WIDTH  request address.
- wr_data  input  DATA_WIDTH  write data.
- ack_vld  output  1  one-cycle completion strobe.
- rd_data  output  DATA_WIDTH  read data, valid while ack_vld=1.
- err  output  1  error flag, valid while ack_vld=1.
- PSEL  output  1  APB select.
- PENABLE  output  1  APB enable.
- PWRITE  output  1  APB direction.
- PADDR  output  ADDR_WIDTH  APB address.
- PWDATA  output  DATA_WIDTH  APB write data.
- PREADY  input  1  APB ready.
- PRDATA  input  DATA_WIDTH  APB read data.
- PSLVERR  input  1  APB slave error.

Behaviour:
- Clock and reset: one clock, fsm_clk; reset fsm_rstn is asynchronous, active-low.
- Reset values (fsm_rstn=0, or soft_rst=1 at an edge): all outputs 0; FSM in IDLE; timeout counter 0.
- FSM states: IDLE, SETUP, ACCESS, ACK. All outputs are registered.
- IDLE:
  - On req_vld=1, latch addr, wr_data and PWRITE=wr_en, then go to SETUP. If wr_en and rd_en are both 1, the request is a write.
  - On req_vld=1 with wr_en=rd_en=0, go directly to ACK with rd_data=0 and err=0; no APB cycle is issued.
- SETUP: PSEL=1, PENABLE=0; PADDR, PWDATA and PWRITE are stable. Always proceeds to ACCESS after one cycle.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - On a clock edge with PREADY=1: capture rd_data=PRDATA for reads or 0 for writes, capture err=PSLVERR, drop PSEL/PENABLE, go to ACK.
- ACK: ack_vld=1 for exactly one cycle with rd_data and err; then return to IDLE. rd_data and err clear to 0 when ack_vld deasserts.
- Latency: with zero-wait-state PREADY, req_vld at edge N gives SETUP at N+1, ACCESS at N+2, ack_vld high at N+3. Each APB wait state adds one cycle.
- req_vld while not in IDLE is ignored (no queueing). Upstream guarantees one outstanding request.
- PADDR and PWDATA hold their last value after a transfer; only PSEL and PENABLE return to 0.
- Reset mid-transfer: outputs drop asynchronously; no ack is issued for the aborted request.
- soft_rst mid-transfer: outputs drop at the next edge; no ack is issued.

Optional Feature:
- Macro: REG_NATIVE2APB_TIMEOUT_EN.
- When defined:
  - A counter increments every ACCESS cycle with PREADY=0.
  - When the count reaches TIMEOUT_CYCLES, drop PSEL/PENABLE and go to ACK with rd_data all-ones and err=1.
  - The counter clears on entry to SETUP.
  - If PREADY=1 on the same edge as the count is reached, PREADY wins: normal completion.
- When undefined: no counter logic; ACCESS waits indefinitely for PREADY.

Test Plan:
- Write, zero wait states: req_vld with wr_en=1, addr=0x10, wr_data=0xA5A5A5A5.
  - Expect PSEL at +1, PENABLE at +2 with PWRITE=1, PWDATA=0xA5A5A5A5.
  - Expect ack_vld at +3 with rd_data=0, err=0.
- Read, 3 wait states: PRDATA=0x12345678, PREADY held low 3 cycles.
  - Expect ack_vld at +6 with rd_data=0x12345678.
  - Expect PSEL/PENABLE held high throughout the wait states.
- PSLVERR on a read: PSLVERR=1 together with PREADY.
  - Expect ack_vld with err=1 for one cycle; err=0 on the next cycle.
- Illegal and overlapping requests:
  - wr_en=rd_en=0 -> ack_vld at +1 with rd_data=0 and no PSEL.
  - A second req_vld during ACCESS -> ignored; exactly one ack is produced.
- Reset and soft reset mid-ACCESS:
  - Drop fsm_rstn -> PSEL/PENABLE go to 0 immediately; no ack_vld.
  - Repeat with soft_rst -> same result at the next edge.
  - A following write completes normally.
- With REG_NATIVE2APB_TIMEOUT_EN, TIMEOUT_CYCLES=4, PREADY stuck at 0:
  - Expect ack_vld with rd_data=0xFFFFFFFF, err=1 after 4 ACCESS cycles.
  - Without the macro, no ack_vld within 100 cycles.
